// File: rtl/alarm_monitor_pkg.sv
// Shared state encodings and status-digit codes for the
// multi-sensor alarm monitor.
package alarm_monitor_pkg;

   typedef enum logic [2:0] {
      INIT        = 3'd0,
      MONITOR     = 3'd1,
      ALERT_CURR  = 3'd2,
      ALERT_SMOKE = 3'd3,
      SILENCED    = 3'd4
   } state_t;

   localparam logic [15:0] HEX_INIT   = 16'h0000;
   localparam logic [15:0] HEX_NORMAL = 16'h8497;
   localparam logic [15:0] HEX_CURR   = 16'h1234;
   localparam logic [15:0] HEX_SMOKE  = 16'h5670;

endpackage

// File: rtl/persist_counter.sv
// Saturating persistence counter; confirmed pulses on the cycle whose
// edge brings the count to PERSIST.
module persist_counter #(
   parameter int PERSIST = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic cond,
   output logic confirmed,
   output logic sat
);

   localparam int CW = $clog2(PERSIST + 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (en && cond) begin
         if (cnt != CW'(PERSIST))
            cnt <= cnt + CW'(1);
      end else begin
         cnt <= '0;
      end
   end

   assign confirmed = en && cond && (cnt == CW'(PERSIST - 1));
   assign sat       = (cnt == CW'(PERSIST));

endmodule

// File: rtl/multi_sensor_alarm_fsm.sv
// Multi-channel overcurrent + smoke alarm monitor with latched alarms.
// Optional LuzAlerta blinking in alert states: define ALARM_BLINK_EN.
module multi_sensor_alarm_fsm
   import alarm_monitor_pkg::*;
#(
   parameter int W         = 3,
   parameter int NCH       = 2,
   parameter int THRESH    = 4,
   parameter int PERSIST   = 4,
   parameter int BLINK_DIV = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             humo,
   input  logic [NCH*W-1:0] corriente,
   input  logic             ack,
   output logic             LuzNormal,
   output logic             LuzAlerta,
   output logic             AlarmaAlerta,
   output logic [NCH-1:0]   fault_mask,
   output logic [3:0]       hexa3,
   output logic [3:0]       hexa2,
   output logic [3:0]       hexa1,
   output logic [3:0]       hexa0
);

   state_t        state;
   state_t        nxt;
   logic          sil_smoke;
   logic [15:0]   hex;
   logic [NCH:0]  conf;
   logic [NCH:0]  sat_unused;
   logic [NCH-1:0] over;
   logic          run;
   logic          smoke_conf;
   logic          curr_conf;
   logic          curr_raw;

   assign run = (state != INIT);

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      assign over[i] = corriente[i*W +: W] >= W'(THRESH);

      persist_counter #(.PERSIST(PERSIST)) u_cnt (
         .clk       (clk),
         .reset     (reset),
         .en        (run),
         .cond      (over[i]),
         .confirmed (conf[i]),
         .sat       (sat_unused[i])
      );
   end

   persist_counter #(.PERSIST(PERSIST)) u_smoke (
      .clk       (clk),
      .reset     (reset),
      .en        (run),
      .cond      (humo),
      .confirmed (conf[NCH]),
      .sat       (sat_unused[NCH])
   );

   assign smoke_conf = conf[NCH];
   assign curr_conf  = |conf[NCH-1:0];
   assign curr_raw   = |over;

   always_comb begin
      nxt = state;
      case (state)
         INIT: nxt = MONITOR;
         MONITOR: begin
            if (smoke_conf)     nxt = ALERT_SMOKE;
            else if (curr_conf) nxt = ALERT_CURR;
         end
         ALERT_CURR: begin
            if (smoke_conf) nxt = ALERT_SMOKE;
            else if (ack)   nxt = curr_raw ? SILENCED : MONITOR;
         end
         ALERT_SMOKE: begin
            if (ack) nxt = humo ? SILENCED : MONITOR;
         end
         SILENCED: begin
            // the other source re-arms the horn before the quiet exit
            if (sil_smoke) begin
               if (curr_conf)  nxt = ALERT_CURR;
               else if (!humo) nxt = MONITOR;
            end else begin
               if (smoke_conf)     nxt = ALERT_SMOKE;
               else if (!curr_raw) nxt = MONITOR;
            end
         end
         default: nxt = INIT;
      endcase
   end

`ifdef ALARM_BLINK_EN
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   logic [BW-1:0] blink_cnt;
`else
   logic blink_div_unused;
   assign blink_div_unused = |BLINK_DIV;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= INIT;
         sil_smoke    <= 1'b0;
         fault_mask   <= '0;
         LuzNormal    <= 1'b1;
         LuzAlerta    <= 1'b0;
         AlarmaAlerta <= 1'b0;
         hex          <= HEX_INIT;
`ifdef ALARM_BLINK_EN
         blink_cnt    <= '0;
`endif
      end else begin
         state <= nxt;
         if (nxt == MONITOR && state != MONITOR)
            fault_mask <= '0;
         else
            fault_mask <= fault_mask | conf[NCH-1:0];
         if (nxt == SILENCED && state != SILENCED)
            sil_smoke <= (state == ALERT_SMOKE);
`ifdef ALARM_BLINK_EN
         blink_cnt <= '0;
`endif
         case (nxt)
            MONITOR: begin
               LuzNormal    <= 1'b1;
               LuzAlerta    <= 1'b0;
               AlarmaAlerta <= 1'b0;
               hex          <= HEX_NORMAL;
            end
            ALERT_CURR, ALERT_SMOKE: begin
               LuzNormal    <= 1'b0;
               AlarmaAlerta <= 1'b1;
               hex          <= (nxt == ALERT_SMOKE) ? HEX_SMOKE : HEX_CURR;
`ifdef ALARM_BLINK_EN
               if (nxt != state) begin
                  LuzAlerta <= 1'b1;
               end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
                  LuzAlerta <= ~LuzAlerta;
               end else begin
                  blink_cnt <= blink_cnt + BW'(1);
               end
`else
               LuzAlerta    <= 1'b1;
`endif
            end
            SILENCED: begin
               LuzNormal    <= 1'b0;
               LuzAlerta    <= 1'b1;
               AlarmaAlerta <= 1'b0;
            end
            default: begin
               LuzNormal    <= 1'b1;
               LuzAlerta    <= 1'b0;
               AlarmaAlerta <= 1'b0;
               hex          <= HEX_INIT;
            end
         endcase
      end
   end

   assign {hexa3, hexa2, hexa1, hexa0} = hex;

endmodule

// File: tb/tb_multi_sensor_alarm_fsm.sv
// Directed self-checking bench for multi_sensor_alarm_fsm
// (default parameters, blink feature disabled).
module tb_multi_sensor_alarm_fsm;

   logic       clk = 1'b0;
   logic       reset;
   logic       humo;
   logic [5:0] corriente;
   logic       ack;
   logic       LuzNormal;
   logic       LuzAlerta;
   logic       AlarmaAlerta;
   logic [1:0] fault_mask;
   logic [3:0] hexa3, hexa2, hexa1, hexa0;

   int passed = 0;
   int total  = 0;

   multi_sensor_alarm_fsm dut (
      .clk          (clk),
      .reset        (reset),
      .humo         (humo),
      .corriente    (corriente),
      .ack          (ack),
      .LuzNormal    (LuzNormal),
      .LuzAlerta    (LuzAlerta),
      .AlarmaAlerta (AlarmaAlerta),
      .fault_mask   (fault_mask),
      .hexa3        (hexa3),
      .hexa2        (hexa2),
      .hexa1        (hexa1),
      .hexa0        (hexa0)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic ln,
                          input logic la, input logic horn,
                          input logic [15:0] hx, input logic [1:0] fm);
      chk({tag, ".LuzNormal"}, 32'(LuzNormal), 32'(ln));
      chk({tag, ".LuzAlerta"}, 32'(LuzAlerta), 32'(la));
      chk({tag, ".horn"}, 32'(AlarmaAlerta), 32'(horn));
      chk({tag, ".hex"}, 32'({hexa3, hexa2, hexa1, hexa0}), 32'(hx));
      chk({tag, ".fault_mask"}, 32'(fault_mask), 32'(fm));
   endtask

   initial begin
      reset = 1'b1;
      humo = 1'b0;
      corriente = 6'd0;
      ack = 1'b0;
      #1;
      chk_out("reset", 1, 0, 0, 16'h0000, 2'b00);
      tick(2);
      reset = 1'b0;
      chk_out("init", 1, 0, 0, 16'h0000, 2'b00);
      tick(1);
      chk_out("monitor", 1, 0, 0, 16'h8497, 2'b00);

      // ch1 over for 3 cycles only: no alert
      corriente = {3'd5, 3'd0};
      tick(3);
      chk_out("ch1_3cyc", 1, 0, 0, 16'h8497, 2'b00);
      corriente = 6'd0;
      tick(1);
      chk_out("ch1_clear", 1, 0, 0, 16'h8497, 2'b00);
      corriente = {3'd5, 3'd0};
      tick(3);
      chk_out("ch1_pre", 1, 0, 0, 16'h8497, 2'b00);
      tick(1);
      chk_out("alert_curr", 0, 1, 1, 16'h1234, 2'b10);

      // condition clears, no ack: stays latched
      corriente = 6'd0;
      tick(3);
      chk_out("latched", 0, 1, 1, 16'h1234, 2'b10);
      ack = 1'b1;
      tick(1);
      chk_out("ack_curr", 1, 0, 0, 16'h8497, 2'b00);
      ack = 1'b0;

      // smoke and ch0 together: smoke wins
      humo = 1'b1;
      corriente = {3'd0, 3'd4};
      tick(3);
      chk_out("both_pre", 1, 0, 0, 16'h8497, 2'b00);
      tick(1);
      chk_out("alert_smoke", 0, 1, 1, 16'h5670, 2'b01);
      ack = 1'b1;
      tick(1);
      chk_out("silenced_smk", 0, 1, 0, 16'h5670, 2'b01);
      ack = 1'b0;
      tick(2);
      chk_out("silenced_hold", 0, 1, 0, 16'h5670, 2'b01);
      humo = 1'b0;
      corriente = 6'd0;
      tick(1);
      chk_out("smoke_gone", 1, 0, 0, 16'h8497, 2'b00);

      // silenced current alert re-armed by smoke confirmation
      corriente = {3'd0, 3'd7};
      tick(4);
      chk_out("alert_curr0", 0, 1, 1, 16'h1234, 2'b01);
      ack = 1'b1;
      tick(1);
      chk_out("silenced_cur", 0, 1, 0, 16'h1234, 2'b01);
      ack = 1'b0;
      humo = 1'b1;
      tick(3);
      chk_out("sil_smk_pre", 0, 1, 0, 16'h1234, 2'b01);
      tick(1);
      chk_out("rearm_smoke", 0, 1, 1, 16'h5670, 2'b01);
      humo = 1'b0;
      corriente = 6'd0;
      ack = 1'b1;
      tick(1);
      chk_out("back_mon", 1, 0, 0, 16'h8497, 2'b00);
      ack = 1'b0;

      // reset asserted mid ALERT_CURR
      corriente = {3'd4, 3'd0};
      tick(4);
      chk_out("alert_curr1", 0, 1, 1, 16'h1234, 2'b10);
      reset = 1'b1;
      #1;
      chk_out("rst_mid", 1, 0, 0, 16'h0000, 2'b00);
      corriente = 6'd0;
      reset = 1'b0;
      tick(1);
      chk_out("post_rst", 1, 0, 0, 16'h8497, 2'b00);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
